// File: rtl/booth_r4_seq_mul.sv
`default_nettype none
// ============================================================================
//  Module   : booth_r4_seq_mul
//  Purpose  : Iterative radix-4 Booth multiplier for unsigned operands with a
//             per-operation selectable approximation of the low M multiplicand
//             bits. DPC Booth digits are retired per clock into a 2N-bit
//             accumulator; valid/ready handshakes on both sides.
//  Ports    : clk        - clock, rising edge
//             rst        - synchronous reset, active high
//             in_valid   - operands present
//             in_ready   - block can accept operands (IDLE)
//             in_x       - multiplicand, N bits, unsigned
//             in_y       - multiplier, N bits, unsigned
//             in_approx  - 1 = approximate mode, 0 = exact mode
//             out_valid  - product valid (DONE)
//             out_ready  - consumer accepts product
//             out_p      - product, 2N bits
//             out_approx - mode under which out_p was computed
//  Revision : 1.0 - initial release
// ============================================================================
module booth_r4_seq_mul #(
   parameter int N   = 32,
   parameter int M   = 16,
   parameter int DPC = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_x,
   input  logic [N-1:0]   in_y,
   input  logic           in_approx,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] out_p,
   output logic           out_approx
);

   localparam int K  = N / 2 + 1;              // total Booth digits
   localparam int CW = $clog2(K + DPC + 1);    // digit counter width
   localparam int YW = N + 3;                  // {0,0,y,0}

   localparam logic [CW-1:0] K_C   = CW'(K);
   localparam logic [CW-1:0] DPC_C = CW'(DPC);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]     state;
   logic [1:0]     state_nxt;
   logic [N-1:0]   x_op;       // exact x, or preprocessed x' in approx mode
   logic [YW-1:0]  ysr;        // multiplier window, consumed 2*DPC bits/cycle
   logic           mode;
   logic [CW-1:0]  k;          // index of next digit to retire
   logic [2*N-1:0] acc;
   logic [2*N-1:0] acc_nxt;
   logic [N-1:0]   xp_in;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic. BUSY leaves only on the cycle after the counter has
   // passed the last digit, which gives the ceil(K/DPC)+1 result latency.
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (in_valid)  state_nxt = S_BUSY;
         S_BUSY:  if (k >= K_C)  state_nxt = S_DONE;
         S_DONE:  if (out_ready) state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output decode
   // ------------------------------------------------------------------------
   always_comb begin
      in_ready  = (state == S_IDLE);
      out_valid = (state == S_DONE);
   end

   assign out_p      = acc;
   assign out_approx = mode;

   // ------------------------------------------------------------------------
   // Approximate-mode multiplicand preprocessing: the low M bits collapse to
   // a single majority bit at position M-1.
   // ------------------------------------------------------------------------
   always_comb begin : p_pre
      int pc;
      pc    = 0;
      xp_in = in_x;
      for (int t = 0; t < M; t++) begin
         pc = pc + int'(in_x[t]);
      end
      for (int t = 0; t < M - 1; t++) begin
         xp_in[t] = 1'b0;
      end
      xp_in[M-1] = (pc > M / 2);
   end

   // ------------------------------------------------------------------------
   // Partial products for the DPC digits of this cycle. Digits beyond the
   // last one see triplet 000 and contribute nothing, so no masking needed.
   // ------------------------------------------------------------------------
   always_comb begin : p_digits
      logic [2:0]     trip;
      logic           neg;
      logic           zero;
      logic           two;
      logic [N+1:0]   mag;
      logic [N+1:0]   pp;
      logic [N:0]     xe;
      logic [2*N-1:0] ppx;
      int             sh;
      acc_nxt = acc;
      xe      = {1'b0, x_op};
      for (int j = 0; j < DPC; j++) begin
         trip = ysr[2*j +: 3];
         neg  = trip[2] & ~(trip[1] & trip[0]);
         zero = (trip == 3'b000) | (trip == 3'b111);
         two  = (trip == 3'b011) | (trip == 3'b100);
         mag  = two ? {1'b0, x_op, 1'b0} : {2'b00, x_op};
         pp   = '0;
         if (!mode) begin
            if (!zero) begin
               pp = neg ? ((~mag) + {{(N+1){1'b0}}, 1'b1}) : mag;
            end
         end else begin
            // Below M the 2A selection is ignored and negation is a plain
            // one's complement; the +1 is folded in by OR at bit 0.
            for (int t = 0; t < M; t++) begin
               pp[t] = (~xe[t] & neg) | (xe[t] & ~neg & ~zero);
            end
            for (int t = M; t <= N; t++) begin
               pp[t] = ~zero & (neg ^ (two ? xe[t-1] : xe[t]));
            end
            pp[N+1] = neg;
            pp[0]   = pp[0] | neg;
         end
         ppx     = {{(N-2){pp[N+1]}}, pp};
         sh      = 2 * (int'(k) + j);
         acc_nxt = acc_nxt + (ppx << sh);
      end
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         acc  <= '0;
         k    <= '0;
         mode <= 1'b0;
         x_op <= '0;
         ysr  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  x_op <= in_approx ? xp_in : in_x;
                  ysr  <= {2'b00, in_y, 1'b0};
                  mode <= in_approx;
                  acc  <= '0;
                  k    <= '0;
               end
            end
            S_BUSY: begin
               if (k < K_C) begin
                  acc <= acc_nxt;
                  k   <= k + DPC_C;
                  ysr <= ysr >> (2 * DPC);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_booth_r4_seq_mul.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_r4_seq_mul
//  Purpose  : Self-checking bench for booth_r4_seq_mul. Four instances with
//             different N/M/DPC share clock and reset; products are compared
//             against an arithmetic reference model of the Booth rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_booth_r4_seq_mul;

   localparam int NU = 4;

   int un [NU] = '{8, 32, 8, 8};
   int um [NU] = '{4, 16, 4, 8};
   int ud [NU] = '{1, 1, 5, 2};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [NU-1:0] iv;
   logic [NU-1:0] ia;
   logic [NU-1:0] ordy;
   logic [31:0]   ix [NU];
   logic [31:0]   iy [NU];
   wire  [NU-1:0] irdy;
   wire  [NU-1:0] ovld;
   wire  [NU-1:0] oap;
   wire  [15:0]   p0;
   wire  [63:0]   p1;
   wire  [15:0]   p2;
   wire  [15:0]   p3;
   logic [63:0]   op [NU];

   always_comb begin
      op[0] = {48'd0, p0};
      op[1] = p1;
      op[2] = {48'd0, p2};
      op[3] = {48'd0, p3};
   end

   booth_r4_seq_mul #(.N(8), .M(4), .DPC(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
      .in_x(ix[0][7:0]), .in_y(iy[0][7:0]), .in_approx(ia[0]),
      .out_valid(ovld[0]), .out_ready(ordy[0]), .out_p(p0), .out_approx(oap[0]));

   booth_r4_seq_mul #(.N(32), .M(16), .DPC(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
      .in_x(ix[1]), .in_y(iy[1]), .in_approx(ia[1]),
      .out_valid(ovld[1]), .out_ready(ordy[1]), .out_p(p1), .out_approx(oap[1]));

   booth_r4_seq_mul #(.N(8), .M(4), .DPC(5)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
      .in_x(ix[2][7:0]), .in_y(iy[2][7:0]), .in_approx(ia[2]),
      .out_valid(ovld[2]), .out_ready(ordy[2]), .out_p(p2), .out_approx(oap[2]));

   booth_r4_seq_mul #(.N(8), .M(8), .DPC(2)) u3 (
      .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(irdy[3]),
      .in_x(ix[3][7:0]), .in_y(iy[3][7:0]), .in_approx(ia[3]),
      .out_valid(ovld[3]), .out_ready(ordy[3]), .out_p(p3), .out_approx(oap[3]));

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: exact mode is plain multiplication; approximate mode sums
   // signed Booth digit contributions built from the approximation rules.
   function automatic logic [63:0] ref_prod(input int n, input int m,
                                            input logic [63:0] x, input logic [63:0] y,
                                            input logic ap);
      logic [63:0] w2, xp, mag, pp, acc, lo, hi;
      int pc, d;
      w2 = (n >= 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*n)) - 64'd1);
      if (!ap) return (x * y) & w2;
      pc = 0;
      for (int t = 0; t < m; t++) pc += int'(x[t]);
      lo = (64'd1 << m) - 64'd1;
      hi = ((64'd1 << (n+1)) - 64'd1) & ~lo;
      xp = x & ~lo;
      if (pc > m/2) xp = xp | (64'd1 << (m-1));
      acc = 64'd0;
      for (int i = 0; i <= n/2; i++) begin
         d = ((i == 0) ? 0 : int'(y[2*i-1])) + int'(y[2*i]) - 2*int'(y[2*i+1]);
         mag = (d == 2 || d == -2) ? (xp << 1) : xp;
         if (d == 0)     pp = 64'd0;
         else if (d < 0) pp = (~mag & hi) | (~xp & lo) | (64'd1 << (n+1)) | 64'd1;
         else            pp = (mag & hi) | (xp & lo);
         if (pp[n+1]) pp = pp | ~((64'd1 << (n+2)) - 64'd1);
         acc = acc + (pp << (2*i));
      end
      return acc & w2;
   endfunction

   task automatic run_op(input int u, input logic [31:0] xin, input logic [31:0] yin,
                         input logic ap, input int stall_max, output logic [63:0] got);
      logic [31:0] x, y, msk;
      logic [63:0] exp;
      int lat, explat, kd, stall;
      msk = (un[u] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << un[u]) - 32'd1);
      x = xin & msk;
      y = yin & msk;
      exp = ref_prod(un[u], um[u], {32'd0, x}, {32'd0, y}, ap);
      kd = un[u]/2 + 1;
      explat = (kd + ud[u] - 1) / ud[u] + 1;
      @(negedge clk);
      check("in_ready", {63'd0, irdy[u]}, 64'd1);
      iv[u] = 1'b1; ix[u] = x; iy[u] = y; ia[u] = ap;
      @(negedge clk);
      iv[u] = 1'b0; ix[u] = $urandom; iy[u] = $urandom; ia[u] = 1'($urandom);
      lat = 0;
      while (!ovld[u] && lat < 200) begin
         lat++;
         @(negedge clk);
      end
      check("latency", 64'(lat), 64'(explat));
      got = op[u];
      check("product", got, exp);
      check("out_approx", {63'd0, oap[u]}, {63'd0, ap});
      stall = $urandom_range(0, stall_max);
      repeat (stall) begin
         ordy[u] = 1'b0;
         @(negedge clk);
         check("hold_valid", {63'd0, ovld[u]}, 64'd1);
         check("hold_p", op[u], exp);
      end
      ordy[u] = 1'b1;
      @(negedge clk);
      ordy[u] = 1'b0;
      check("valid_drop", {63'd0, ovld[u]}, 64'd0);
   endtask

   logic [63:0] got;
   logic [7:0]  cv [5] = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'hFF};

   initial begin
      rst = 1'b1; iv = '0; ia = '0; ordy = '0;
      for (int u = 0; u < NU; u++) begin ix[u] = '0; iy[u] = '0; end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int u = 0; u < NU; u++) begin
         check("rst_in_ready", {63'd0, irdy[u]}, 64'd1);
         check("rst_out_valid", {63'd0, ovld[u]}, 64'd0);
         check("rst_out_p", op[u], 64'd0);
         check("rst_out_approx", {63'd0, oap[u]}, 64'd0);
      end

      // Directed small-width vectors
      run_op(0, 32'hFF, 32'hFF, 1'b0, 2, got); check("x255y255", got, 64'hFE01);
      run_op(0, 32'h0F, 32'h01, 1'b1, 2, got); check("apx_0f_01", got, 64'h0008);
      run_op(0, 32'h03, 32'h02, 1'b1, 2, got); check("apx_03_02", got, 64'hFFFF);
      run_op(0, 32'h03, 32'h02, 1'b0, 2, got); check("exa_03_02", got, 64'h0006);

      // Reset two cycles into BUSY aborts the operation
      @(negedge clk);
      iv[1] = 1'b1; ix[1] = $urandom; iy[1] = $urandom; ia[1] = 1'b0;
      @(negedge clk);
      iv[1] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_in_ready", {63'd0, irdy[1]}, 64'd1);
      check("abort_out_valid", {63'd0, ovld[1]}, 64'd0);
      check("abort_out_p", op[1], 64'd0);
      run_op(1, 32'd3, 32'd5, 1'b0, 1, got); check("after_abort", got, 64'd15);

      // Corner operand combinations on the single-cycle and M=N instances
      for (int a = 0; a < 5; a++)
         for (int b = 0; b < 5; b++) begin
            run_op(2, {24'd0, cv[a]}, {24'd0, cv[b]}, 1'b1, 0, got);
            run_op(2, {24'd0, cv[a]}, {24'd0, cv[b]}, 1'b0, 0, got);
            run_op(3, {24'd0, cv[a]}, {24'd0, cv[b]}, 1'b1, 0, got);
         end

      // Randomized traffic
      for (int i = 0; i < 300; i++)  run_op(0, $urandom, $urandom, 1'($urandom), 3, got);
      for (int i = 0; i < 800; i++)  run_op(1, $urandom, $urandom, 1'b0, 3, got);
      for (int i = 0; i < 400; i++)  run_op(1, $urandom, $urandom, 1'b1, 3, got);
      for (int i = 0; i < 3000; i++) run_op(2, $urandom, $urandom, 1'b1, 1, got);
      for (int i = 0; i < 500; i++)  run_op(3, $urandom, $urandom, 1'($urandom), 2, got);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
